// File: rtl/dct_pkg.sv
// Shared sizes, bank-state encoding and index types for the row-DCT
// sequencer and its transpose buffer.
package dct_pkg;

  localparam int N     = 8;
  localparam int IN_W  = 11;
  localparam int CO_W  = 14;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    WAIT,
    FULL
  } bank_st_t;

  typedef logic [IDX_W-1:0] row_idx_t;
  typedef logic [IDX_W-1:0] col_idx_t;

endpackage

// File: rtl/dct_tbuf.sv
// Two-bank transpose buffer: rows are written whole, columns are read whole.
// Contents are data only and carry no reset.
module dct_tbuf
  import dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic                   wr_bank,
  input  row_idx_t               wr_row,
  input  logic signed [CO_W-1:0] wr_data [N],
  input  logic                   rd_bank,
  input  col_idx_t               rd_col,
  output logic signed [CO_W-1:0] rd_data [N]
);

  logic signed [CO_W-1:0] mem [2][N][N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_bank][wr_row][c] <= wr_data[c];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      rd_data[r] = mem[rd_bank][r][rd_col];
    end
  end

endmodule

// File: rtl/dct_row_sched.sv
// Row issue, coefficient capture and column drain around the row_dct core,
// using a ping-pong transpose buffer so both sides run one block per N cycles.
module dct_row_sched #(
  parameter int N    = dct_pkg::N,
  parameter int IN_W = dct_pkg::IN_W,
  parameter int CO_W = dct_pkg::CO_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic signed [IN_W-1:0] i_data0,
  input  logic signed [IN_W-1:0] i_data1,
  input  logic signed [IN_W-1:0] i_data2,
  input  logic signed [IN_W-1:0] i_data3,
  input  logic signed [IN_W-1:0] i_data4,
  input  logic signed [IN_W-1:0] i_data5,
  input  logic signed [IN_W-1:0] i_data6,
  input  logic signed [IN_W-1:0] i_data7,
  output logic                   o_core_valid,
  output logic signed [IN_W-1:0] o_core_data0,
  output logic signed [IN_W-1:0] o_core_data1,
  output logic signed [IN_W-1:0] o_core_data2,
  output logic signed [IN_W-1:0] o_core_data3,
  output logic signed [IN_W-1:0] o_core_data4,
  output logic signed [IN_W-1:0] o_core_data5,
  output logic signed [IN_W-1:0] o_core_data6,
  output logic signed [IN_W-1:0] o_core_data7,
  input  logic                   i_core_valid,
  input  logic signed [CO_W-1:0] i_core_data0,
  input  logic signed [CO_W-1:0] i_core_data1,
  input  logic signed [CO_W-1:0] i_core_data2,
  input  logic signed [CO_W-1:0] i_core_data3,
  input  logic signed [CO_W-1:0] i_core_data4,
  input  logic signed [CO_W-1:0] i_core_data5,
  input  logic signed [CO_W-1:0] i_core_data6,
  input  logic signed [CO_W-1:0] i_core_data7,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic signed [CO_W-1:0] o_col_data0,
  output logic signed [CO_W-1:0] o_col_data1,
  output logic signed [CO_W-1:0] o_col_data2,
  output logic signed [CO_W-1:0] o_col_data3,
  output logic signed [CO_W-1:0] o_col_data4,
  output logic signed [CO_W-1:0] o_col_data5,
  output logic signed [CO_W-1:0] o_col_data6,
  output logic signed [CO_W-1:0] o_col_data7,
  output logic [2:0]             o_col_idx,
  output logic                   o_last,
  output logic                   o_err
);

  import dct_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  bank_st_t st [2];
  bank_st_t st_nxt [2];
  logic     wp, cp, rp;
  row_idx_t ir, cr;
  col_idx_t col;
  logic     err;
  logic     accept, cap_ok, cap, spurious, drain;

  logic signed [CO_W-1:0] wr_data [N];
  logic signed [CO_W-1:0] rd_data [N];

  assign o_ready  = (st[wp] == EMPTY) || (st[wp] == FILL);
  assign accept   = i_valid && o_ready;
  assign cap_ok   = (st[cp] == FILL) || (st[cp] == WAIT);
  assign cap      = i_core_valid && cap_ok;
  assign spurious = i_core_valid && !cap_ok;
  assign o_valid  = (st[rp] == FULL);
  assign drain    = o_valid && i_ready;

  assign o_core_valid = accept;
  assign o_core_data0 = i_data0;
  assign o_core_data1 = i_data1;
  assign o_core_data2 = i_data2;
  assign o_core_data3 = i_data3;
  assign o_core_data4 = i_data4;
  assign o_core_data5 = i_data5;
  assign o_core_data6 = i_data6;
  assign o_core_data7 = i_data7;

  // The three events can only ever target a bank in disjoint states, so
  // their updates never collide on the same bank in one cycle.
  always_comb begin
    st_nxt[0] = st[0];
    st_nxt[1] = st[1];
    if (accept) st_nxt[wp] = (ir == LAST) ? WAIT : FILL;
    if (cap && (cr == LAST)) st_nxt[cp] = FULL;
    if (drain && (col == LAST)) st_nxt[rp] = EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      wp    <= 1'b0;
      cp    <= 1'b0;
      rp    <= 1'b0;
      ir    <= '0;
      cr    <= '0;
      col   <= '0;
      err   <= 1'b0;
    end else begin
      st[0] <= st_nxt[0];
      st[1] <= st_nxt[1];
      if (accept) begin
        ir <= (ir == LAST) ? '0 : ir + 1'b1;
        if (ir == LAST) wp <= ~wp;
      end
      if (cap) begin
        cr <= (cr == LAST) ? '0 : cr + 1'b1;
        if (cr == LAST) cp <= ~cp;
      end
      if (drain) begin
        col <= (col == LAST) ? '0 : col + 1'b1;
        if (col == LAST) rp <= ~rp;
      end
      if (spurious) err <= 1'b1;
    end
  end

  assign wr_data[0] = i_core_data0;
  assign wr_data[1] = i_core_data1;
  assign wr_data[2] = i_core_data2;
  assign wr_data[3] = i_core_data3;
  assign wr_data[4] = i_core_data4;
  assign wr_data[5] = i_core_data5;
  assign wr_data[6] = i_core_data6;
  assign wr_data[7] = i_core_data7;

  dct_tbuf u_tbuf (
    .clk     (i_clk),
    .wr_en   (cap),
    .wr_bank (cp),
    .wr_row  (cr),
    .wr_data (wr_data),
    .rd_bank (rp),
    .rd_col  (col),
    .rd_data (rd_data)
  );

  assign o_col_data0 = rd_data[0];
  assign o_col_data1 = rd_data[1];
  assign o_col_data2 = rd_data[2];
  assign o_col_data3 = rd_data[3];
  assign o_col_data4 = rd_data[4];
  assign o_col_data5 = rd_data[5];
  assign o_col_data6 = rd_data[6];
  assign o_col_data7 = rd_data[7];
  assign o_col_idx   = col;
  assign o_last      = (col == LAST);
  assign o_err       = err;

endmodule

// File: tb/tb_dct_row_sched.sv
// Scoreboard bench for dct_row_sched with a 5-cycle behavioural row core;
// expected columns come from transposing whole blocks of core results.
module tb_dct_row_sched;

  localparam int IN_W = 11;
  localparam int CO_W = 14;

  typedef logic [7:0][IN_W-1:0] pix_row_t;
  typedef logic [7:0][CO_W-1:0] co_row_t;
  typedef struct packed {
    co_row_t    d;
    logic [2:0] idx;
    logic       last;
  } col_t;

  logic     i_clk = 1'b0;
  logic     i_rst = 1'b1;
  logic     i_valid = 1'b0;
  logic     i_ready = 1'b0;
  logic     o_ready, o_core_valid, o_valid, o_last, o_err;
  logic [2:0] o_col_idx;
  pix_row_t din = '0;
  pix_row_t cdat;
  co_row_t  outd;

  // behavioural core: mode 0 = {sum, first differences}, mode 1 = pass-through
  bit       core_mode = 1'b0;
  logic     inj = 1'b0;
  logic     pv [5] = '{default: 1'b0};
  co_row_t  pd [5];
  logic     core_v;
  co_row_t  core_d;

  int       n_tests = 0;
  int       n_fail = 0;
  int       cyc = 0;
  int       rdy_mode = 0;
  col_t     sb [$];
  pix_row_t blk [8];
  int       row_in_blk = 0;
  bit       rec_first = 1'b0;
  int       a_cyc = 0;
  int       v_first = -1;
  int       last_xfer = -1;

  assign core_v = pv[4] | inj;
  assign core_d = pd[4];

  dct_row_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]), .i_data3(din[3]),
    .i_data4(din[4]), .i_data5(din[5]), .i_data6(din[6]), .i_data7(din[7]),
    .o_core_valid(o_core_valid),
    .o_core_data0(cdat[0]), .o_core_data1(cdat[1]), .o_core_data2(cdat[2]),
    .o_core_data3(cdat[3]), .o_core_data4(cdat[4]), .o_core_data5(cdat[5]),
    .o_core_data6(cdat[6]), .o_core_data7(cdat[7]),
    .i_core_valid(core_v),
    .i_core_data0(core_d[0]), .i_core_data1(core_d[1]), .i_core_data2(core_d[2]),
    .i_core_data3(core_d[3]), .i_core_data4(core_d[4]), .i_core_data5(core_d[5]),
    .i_core_data6(core_d[6]), .i_core_data7(core_d[7]),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_col_data0(outd[0]), .o_col_data1(outd[1]), .o_col_data2(outd[2]),
    .o_col_data3(outd[3]), .o_col_data4(outd[4]), .o_col_data5(outd[5]),
    .o_col_data6(outd[6]), .o_col_data7(outd[7]),
    .o_col_idx(o_col_idx), .o_last(o_last), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic co_row_t core_fn(input pix_row_t x, input bit mode);
    co_row_t y;
    int s, t;
    s = 0;
    for (int k = 0; k < 8; k++) s += int'($signed(x[k]));
    for (int k = 0; k < 8; k++) begin
      if (mode) t = int'($signed(x[k]));
      else if (k == 0) t = s;
      else t = int'($signed(x[k])) - int'($signed(x[k-1]));
      y[k] = t[CO_W-1:0];
    end
    return y;
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 5; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= o_core_valid;
      pd[0] <= core_fn(cdat, core_mode);
      for (int i = 1; i < 5; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic push_block();
    co_row_t rows [8];
    col_t e;
    for (int r = 0; r < 8; r++) rows[r] = core_fn(blk[r], core_mode);
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) e.d[r] = rows[r][c];
      e.idx  = 3'(c);
      e.last = (c == 7);
      sb.push_back(e);
    end
  endtask

  // called at #1 after a posedge, returns at #1 after the accepting posedge
  task automatic send_row(input pix_row_t r, input bit idle_rand);
    int n;
    if (idle_rand) begin
      while ($urandom_range(1, 0) != 0) begin
        @(posedge i_clk);
        #1;
      end
    end
    i_valid = 1'b1;
    din = r;
    n = 0;
    forever begin
      @(negedge i_clk);
      if (o_ready) break;
      n++;
      if (n > 400) abort("issue wait");
    end
    chk("core issue", {o_core_valid, cdat}, {1'b1, r});
    if (rec_first) begin
      a_cyc = cyc;
      rec_first = 1'b0;
    end
    blk[row_in_blk] = r;
    row_in_blk++;
    if (row_in_blk == 8) begin
      push_block();
      row_in_blk = 0;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_rand_block(input bit idle_rand);
    pix_row_t pr;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) pr[k] = IN_W'($urandom);
      send_row(pr, idle_rand);
    end
  endtask

  task automatic drain_wait(input string name);
    int n = 0;
    while (sb.size() != 0) begin
      @(negedge i_clk);
      n++;
      if (n > 2000) abort(name);
    end
    repeat (3) @(posedge i_clk);
    #1;
    chk({name, " idle"}, {o_valid, o_err}, 2'b00);
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = 1'($urandom_range(1, 0));
        default: i_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    col_t act, prev_out, exp;
    bit   prev_stall;
    prev_stall = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge i_clk);
      act = {outd, o_col_idx, o_last};
      if (i_rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) chk("stall hold", {o_valid, act}, {1'b1, prev_out});
      if (o_valid && v_first < 0) v_first = cyc;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected column: got %0h expected none", act);
        end else begin
          exp = sb.pop_front();
          chk("column", act, exp);
        end
        if (o_last) last_xfer = cyc;
      end
      prev_stall = o_valid && !i_ready;
      prev_out = act;
    end
  end

  initial begin
    #500000;
    abort("global timeout");
  end

  initial begin : stim
    pix_row_t pr;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset o_ready", o_ready, 1'b1);
    chk("reset outputs", {o_valid, o_core_valid, o_last, o_err, o_col_idx}, '0);
    @(posedge i_clk);
    #1;

    // DC block with back-to-back rows
    core_mode = 1'b0;
    rdy_mode = 0;
    v_first = -1;
    last_xfer = -1;
    rec_first = 1'b1;
    for (int k = 0; k < 8; k++) pr[k] = IN_W'(100);
    for (int r = 0; r < 8; r++) send_row(pr, 1'b0);
    drain_wait("dc");
    chk("dc first valid latency", 32'(v_first - a_cyc), 32'd13);
    chk("dc last column latency", 32'(last_xfer - a_cyc), 32'd20);

    // transpose through a pass-through core
    core_mode = 1'b1;
    for (int r = 0; r < 8; r++) begin
      pr = '0;
      pr[0] = IN_W'(r);
      send_row(pr, 1'b0);
    end
    drain_wait("transpose");

    // three blocks against a 30-cycle downstream stall
    core_mode = 1'b0;
    rdy_mode = 2;
    @(posedge i_clk);
    #1;
    fork
      begin
        send_rand_block(1'b0);
        send_rand_block(1'b0);
        @(negedge i_clk);
        chk("backpressure o_ready", o_ready, 1'b0);
        @(posedge i_clk);
        #1;
        send_rand_block(1'b0);
      end
      begin
        repeat (30) @(posedge i_clk);
        rdy_mode = 0;
      end
    join
    drain_wait("backpressure");

    // random valid/ready duty
    rdy_mode = 1;
    for (int b = 0; b < 10; b++) send_rand_block(1'b1);
    drain_wait("random");

    // reset after 4 rows of the second block
    rdy_mode = 0;
    send_rand_block(1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) pr[k] = IN_W'($urandom);
      send_row(pr, 1'b0);
    end
    i_rst = 1'b1;
    sb.delete();
    row_in_blk = 0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post-reset o_ready", o_ready, 1'b1);
    chk("post-reset o_valid", o_valid, 1'b0);
    @(posedge i_clk);
    #1;
    send_rand_block(1'b0);
    drain_wait("after reset");

    // spurious core result with both banks empty
    inj = 1'b1;
    @(posedge i_clk);
    #1;
    inj = 1'b0;
    @(negedge i_clk);
    chk("spurious err set", {o_err, o_valid}, 2'b10);
    repeat (5) @(negedge i_clk);
    chk("spurious err sticky", {o_err, o_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
